// File: rtl/blend_if.sv
// Pixel/control bundle between the picture sources, the compositor and the VGA output.
// The master drives the layer pixels and frame controls; the slave returns the composited stream.
interface blend_if #(
    parameter int CH_BITS    = 4,
    parameter int ALPHA_BITS = 3,
    parameter int CNT_BITS   = 19
);
    logic                    frame_start_in;
    logic [ALPHA_BITS-1:0]   alpha_in;
    logic [1:0]              mode_in;
    logic                    valid_in;
    logic [3*CH_BITS-1:0]    pix_a_in;
    logic [3*CH_BITS-1:0]    pix_b_in;
    logic                    valid_out;
    logic [3*CH_BITS-1:0]    pixel_out;
    logic [CNT_BITS-1:0]     overlap_count_out;
    logic                    count_valid_out;

    modport master (
        output frame_start_in, alpha_in, mode_in, valid_in, pix_a_in, pix_b_in,
        input  valid_out, pixel_out, overlap_count_out, count_valid_out
    );

    modport slave (
        input  frame_start_in, alpha_in, mode_in, valid_in, pix_a_in, pix_b_in,
        output valid_out, pixel_out, overlap_count_out, count_valid_out
    );
endinterface

// File: rtl/blend_pipeline.sv
// Three-stage two-layer pixel compositor (BLEND/OVER/DIFF/PASS_A) with frame-latched
// alpha/mode and a per-frame count of pixels where both layers are non-zero.
module blend_pipeline #(
    parameter int CH_BITS    = 4,
    parameter int ALPHA_BITS = 3,
    parameter int CNT_BITS   = 19
) (
    input logic   clk_in,
    input logic   rst_in,
    blend_if.slave bus
);
    localparam int PIX_W  = 3 * CH_BITS;
    localparam int PROD_W = CH_BITS + ALPHA_BITS;
    localparam int SHIFT  = ALPHA_BITS - 1;
    localparam logic [ALPHA_BITS-1:0] F_A    = ALPHA_BITS'(1) << SHIFT;
    localparam logic [PROD_W-1:0]     CH_MAX = PROD_W'((1 << CH_BITS) - 1);

    typedef enum logic [1:0] {
        MODE_BLEND  = 2'd0,
        MODE_OVER   = 2'd1,
        MODE_DIFF   = 2'd2,
        MODE_PASS_A = 2'd3
    } mode_e;

    function automatic logic [ALPHA_BITS-1:0] clamp_alpha(input logic [ALPHA_BITS-1:0] al);
        return (al > F_A) ? F_A : al;
    endfunction

    function automatic logic [CH_BITS-1:0] sat_ch(input logic [PROD_W-1:0] v);
        return (v > CH_MAX) ? {CH_BITS{1'b1}} : v[CH_BITS-1:0];
    endfunction

    function automatic logic [CH_BITS-1:0] abs_diff(input logic [CH_BITS-1:0] x,
                                                    input logic [CH_BITS-1:0] y);
        logic signed [CH_BITS:0] d;
        d = $signed({1'b0, x}) - $signed({1'b0, y});
        return (d < 0) ? CH_BITS'(-d) : CH_BITS'(d);
    endfunction

    // Frame-latched controls and overlap counter
    logic [ALPHA_BITS-1:0] alpha_sh_q, alpha_sh_d;
    mode_e                 mode_sh_q, mode_sh_d;
    logic [CNT_BITS-1:0]   run_q, run_d;
    logic [CNT_BITS-1:0]   cnt_out_q, cnt_out_d;
    logic                  cv_q, cv_d;

    logic [ALPHA_BITS-1:0] alpha_eff, a_c, n_c;
    mode_e                 mode_eff;
    logic                  a_nz_c, b_nz_c, ovl_c;

    always_comb begin
        alpha_eff = bus.frame_start_in ? bus.alpha_in : alpha_sh_q;
        mode_eff  = bus.frame_start_in ? mode_e'(bus.mode_in) : mode_sh_q;
        a_c       = clamp_alpha(alpha_eff);
        n_c       = F_A - a_c;
        a_nz_c    = |bus.pix_a_in;
        b_nz_c    = |bus.pix_b_in;
        ovl_c     = bus.valid_in & a_nz_c & b_nz_c;
    end

    always_comb begin
        alpha_sh_d = alpha_sh_q;
        mode_sh_d  = mode_sh_q;
        run_d      = run_q;
        cnt_out_d  = cnt_out_q;
        cv_d       = 1'b0;
        if (bus.frame_start_in) begin
            alpha_sh_d = bus.alpha_in;
            mode_sh_d  = mode_e'(bus.mode_in);
            cnt_out_d  = run_q;
            cv_d       = 1'b1;
            // the frame-start pixel already belongs to the new frame
            run_d      = CNT_BITS'(ovl_c);
        end else if (ovl_c && (run_q != {CNT_BITS{1'b1}})) begin
            run_d = run_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            alpha_sh_q <= F_A >> 1;
            mode_sh_q  <= MODE_BLEND;
            run_q      <= '0;
            cnt_out_q  <= '0;
            cv_q       <= 1'b0;
        end else begin
            alpha_sh_q <= alpha_sh_d;
            mode_sh_q  <= mode_sh_d;
            run_q      <= run_d;
            cnt_out_q  <= cnt_out_d;
            cv_q       <= cv_d;
        end
    end

    // S1: capture pixels with their effective weights and mode
    logic                  vld_p1_q;
    logic [PIX_W-1:0]      pa_p1_q, pb_p1_q;
    logic [ALPHA_BITS-1:0] a_p1_q, n_p1_q;
    mode_e                 mode_p1_q;
    logic                  anz_p1_q, bnz_p1_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) vld_p1_q <= 1'b0;
        else        vld_p1_q <= bus.valid_in;
        pa_p1_q   <= bus.pix_a_in;
        pb_p1_q   <= bus.pix_b_in;
        a_p1_q    <= a_c;
        n_p1_q    <= n_c;
        mode_p1_q <= mode_eff;
        anz_p1_q  <= a_nz_c;
        bnz_p1_q  <= b_nz_c;
    end

    // S2: per-channel weighted products and absolute differences
    logic                 vld_p2_q;
    logic [PROD_W-1:0]    pra_p2_q [3];
    logic [PROD_W-1:0]    prb_p2_q [3];
    logic [CH_BITS-1:0]   dif_p2_q [3];
    logic [PIX_W-1:0]     pa_p2_q, pb_p2_q;
    mode_e                mode_p2_q;
    logic                 both_nz_p2_q, bnz_p2_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) vld_p2_q <= 1'b0;
        else        vld_p2_q <= vld_p1_q;
        for (int c = 0; c < 3; c++) begin
            pra_p2_q[c] <= PROD_W'(pa_p1_q[c*CH_BITS +: CH_BITS]) * PROD_W'(a_p1_q);
            prb_p2_q[c] <= PROD_W'(pb_p1_q[c*CH_BITS +: CH_BITS]) * PROD_W'(n_p1_q);
            dif_p2_q[c] <= abs_diff(pa_p1_q[c*CH_BITS +: CH_BITS], pb_p1_q[c*CH_BITS +: CH_BITS]);
        end
        pa_p2_q      <= pa_p1_q;
        pb_p2_q      <= pb_p1_q;
        mode_p2_q    <= mode_p1_q;
        both_nz_p2_q <= anz_p1_q & bnz_p1_q;
        bnz_p2_q     <= bnz_p1_q;
    end

    // S3: mode select into the output register
    logic [PIX_W-1:0] blend_c, sel_c;
    logic [PIX_W-1:0] pix_out_q, pix_out_d;
    logic             vld_out_q;

    always_comb begin
        blend_c = pa_p2_q | pb_p2_q;
        if (both_nz_p2_q) begin
            for (int c = 0; c < 3; c++) begin
                blend_c[c*CH_BITS +: CH_BITS] = sat_ch((pra_p2_q[c] >> SHIFT) + (prb_p2_q[c] >> SHIFT));
            end
        end
        sel_c = pa_p2_q;
        case (mode_p2_q)
            MODE_BLEND: sel_c = blend_c;
            MODE_OVER:  sel_c = bnz_p2_q ? pb_p2_q : pa_p2_q;
            MODE_DIFF: begin
                for (int c = 0; c < 3; c++) sel_c[c*CH_BITS +: CH_BITS] = dif_p2_q[c];
            end
            default:    sel_c = pa_p2_q;
        endcase
        pix_out_d = vld_p2_q ? sel_c : pix_out_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld_out_q <= 1'b0;
            pix_out_q <= '0;
        end else begin
            vld_out_q <= vld_p2_q;
            pix_out_q <= pix_out_d;
        end
    end

    assign bus.valid_out         = vld_out_q;
    assign bus.pixel_out         = pix_out_q;
    assign bus.overlap_count_out = cnt_out_q;
    assign bus.count_valid_out   = cv_q;

endmodule

// File: tb/tb_blend_pipeline.sv
// Bench for blend_pipeline: directed scenarios plus a randomized stream against a
// cycle-indexed reference of the compositing rules.
module tb_blend_pipeline;
    localparam int CH = 4;
    localparam int AB = 3;
    localparam int CB = 19;
    localparam int F  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    blend_if #(.CH_BITS(CH), .ALPHA_BITS(AB), .CNT_BITS(CB)) bif ();
    blend_pipeline #(.CH_BITS(CH), .ALPHA_BITS(AB), .CNT_BITS(CB)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bif)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    bit          hv [4096];
    logic [11:0] hp [4096];
    int          sh_alpha, sh_mode;
    int          run_cnt;
    int          exp_cnt;
    bit          exp_cv, exp_vld;
    logic [11:0] exp_pix;

    function automatic logic [11:0] ref_pix(logic [11:0] a, logic [11:0] b, int alpha, int mode);
        int al;
        int ca, cb, r;
        logic [11:0] res;
        al  = (alpha > F) ? F : alpha;
        res = a;
        case (mode)
            0: begin
                if (a != 0 && b != 0) begin
                    for (int c = 0; c < 3; c++) begin
                        ca = (a >> (4 * c)) & 15;
                        cb = (b >> (4 * c)) & 15;
                        r  = (ca * al) / F + (cb * (F - al)) / F;
                        if (r > 15) r = 15;
                        res[4*c +: 4] = r[3:0];
                    end
                end else begin
                    res = a | b;
                end
            end
            1: res = (b != 0) ? b : a;
            2: begin
                for (int c = 0; c < 3; c++) begin
                    ca = (a >> (4 * c)) & 15;
                    cb = (b >> (4 * c)) & 15;
                    r  = (ca > cb) ? ca - cb : cb - ca;
                    res[4*c +: 4] = r[3:0];
                end
            end
            default: res = a;
        endcase
        return res;
    endfunction

    // drive one cycle of inputs, advance the reference, settle just after the edge
    task automatic step(bit r, bit fs, int alpha, int mode, bit v, logic [11:0] a, logic [11:0] b);
        int c;
        bit ovl;
        int ea, em;
        c   = cyc;
        rst = r;
        bif.frame_start_in = fs;
        bif.alpha_in       = alpha[2:0];
        bif.mode_in        = mode[1:0];
        bif.valid_in       = v;
        bif.pix_a_in       = a;
        bif.pix_b_in       = b;
        if (r) begin
            sh_alpha = F / 2; sh_mode = 0; run_cnt = 0; exp_cnt = 0;
            exp_cv = 0; exp_vld = 0; exp_pix = '0;
            hv[c] = 0;
            if (c >= 1) hv[c-1] = 0;
        end else begin
            ea = fs ? alpha : sh_alpha;
            em = fs ? mode : sh_mode;
            if (fs) begin sh_alpha = alpha; sh_mode = mode; end
            ovl   = v && (a != 0) && (b != 0);
            hv[c] = v;
            hp[c] = ref_pix(a, b, ea, em);
            if (fs) begin
                exp_cnt = run_cnt; exp_cv = 1; run_cnt = ovl ? 1 : 0;
            end else begin
                exp_cv = 0;
                if (ovl && run_cnt != (1 << CB) - 1) run_cnt++;
            end
            exp_vld = (c >= 2) ? hv[c-2] : 1'b0;
            if (exp_vld) exp_pix = hp[c-2];
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 12'h000, 12'h000);
    endtask

    function automatic logic [11:0] rnd_pix();
        logic [11:0] p;
        p = 12'($urandom_range(0, 4095));
        if ($urandom_range(0, 3) == 0) p = '0;
        return p;
    endfunction

    task automatic test_reset();
        step(1, 0, 0, 0, 1, 12'hFFF, 12'hFFF);
        step(1, 0, 0, 0, 0, 12'h000, 12'h000);
        n_vec++;
        if (bif.valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bif.valid_out); end
        n_vec++;
        if (bif.pixel_out !== 12'h000) begin n_err++; $display("FAIL reset_pixel: got %h want 000", bif.pixel_out); end
        n_vec++;
        if (bif.overlap_count_out !== 19'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bif.overlap_count_out); end
        n_vec++;
        if (bif.count_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_cv: got %b want 0", bif.count_valid_out); end
    endtask

    task automatic test_blend();
        int          al [3] = '{0, 4, 7};
        logic [11:0] ta [3] = '{12'h0F0, 12'h888, 12'h888};
        logic [11:0] tb [3] = '{12'h000, 12'h444, 12'h444};
        logic [11:0] te [3] = '{12'h0F0, 12'h888, 12'h888};
        step(0, 1, 2, 0, 1, 12'hFFF, 12'hFFF);
        idle(1);
        n_vec++;
        if (bif.valid_out !== 1'b0) begin n_err++; $display("FAIL latency_early: valid_out %b want 0", bif.valid_out); end
        idle(1);
        n_vec++;
        if (bif.valid_out !== 1'b1 || bif.pixel_out !== 12'hEEE) begin
            n_err++; $display("FAIL blend_half: got vld=%b pix=%h want vld=1 pix=eee", bif.valid_out, bif.pixel_out);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, (i == 0) ? 2 : al[i], 0, 1, ta[i], tb[i]);
            idle(2);
            n_vec++;
            if (bif.valid_out !== 1'b1 || bif.pixel_out !== te[i]) begin
                n_err++; $display("FAIL blend_case%0d: got vld=%b pix=%h want vld=1 pix=%h", i, bif.valid_out, bif.pixel_out, te[i]);
            end
        end
    endtask

    task automatic test_shadow();
        step(0, 1, 2, 0, 0, 12'h000, 12'h000);
        step(0, 0, 0, 0, 1, 12'hFFF, 12'hFFF);
        step(0, 1, 0, 0, 1, 12'hFFF, 12'hFFF);
        idle(1);
        n_vec++;
        if (bif.valid_out !== 1'b1 || bif.pixel_out !== 12'hEEE) begin
            n_err++; $display("FAIL shadow_hold: got vld=%b pix=%h want vld=1 pix=eee", bif.valid_out, bif.pixel_out);
        end
        idle(1);
        n_vec++;
        if (bif.valid_out !== 1'b1 || bif.pixel_out !== 12'hFFF) begin
            n_err++; $display("FAIL shadow_same_cycle: got vld=%b pix=%h want vld=1 pix=fff", bif.valid_out, bif.pixel_out);
        end
        step(0, 0, 2, 3, 1, 12'hFFF, 12'hFFF);
        idle(2);
        n_vec++;
        if (bif.valid_out !== 1'b1 || bif.pixel_out !== 12'hFFF) begin
            n_err++; $display("FAIL shadow_latched: got vld=%b pix=%h want vld=1 pix=fff", bif.valid_out, bif.pixel_out);
        end
    endtask

    task automatic test_modes();
        int          md [4] = '{1, 1, 2, 3};
        logic [11:0] ta [4] = '{12'h123, 12'h123, 12'h3A5, 12'h3A5};
        logic [11:0] tb [4] = '{12'h400, 12'h000, 12'h1C2, 12'h1C2};
        logic [11:0] te [4] = '{12'h400, 12'h123, 12'h223, 12'h3A5};
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 2, md[i], 1, ta[i], tb[i]);
            idle(2);
            n_vec++;
            if (bif.valid_out !== 1'b1 || bif.pixel_out !== te[i]) begin
                n_err++; $display("FAIL mode%0d_case%0d: got vld=%b pix=%h want vld=1 pix=%h", md[i], i, bif.valid_out, bif.pixel_out, te[i]);
            end
        end
    endtask

    task automatic test_overlap();
        logic [11:0] pa [10] = '{12'h111, 12'h000, 12'h222, 12'h333, 12'h040, 12'h555, 12'h000, 12'h777, 12'h888, 12'h001};
        logic [11:0] pb [10] = '{12'h111, 12'h123, 12'h202, 12'h000, 12'h004, 12'h000, 12'h000, 12'h070, 12'h008, 12'h100};
        step(0, 1, 2, 0, 0, 12'hFFF, 12'hFFF);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 1, pa[i], pb[i]);
            if (i == 4) step(0, 0, 0, 0, 0, 12'hABC, 12'hABC);
        end
        step(0, 1, 2, 0, 1, 12'h111, 12'h111);
        n_vec++;
        if (bif.overlap_count_out !== 19'd6 || bif.count_valid_out !== 1'b1) begin
            n_err++; $display("FAIL overlap_frame1: got cnt=%0d cv=%b want cnt=6 cv=1", bif.overlap_count_out, bif.count_valid_out);
        end
        idle(1);
        n_vec++;
        if (bif.count_valid_out !== 1'b0 || bif.overlap_count_out !== 19'd6) begin
            n_err++; $display("FAIL overlap_pulse: got cnt=%0d cv=%b want cnt=6 cv=0", bif.overlap_count_out, bif.count_valid_out);
        end
        step(0, 0, 0, 0, 1, 12'h123, 12'h000);
        step(0, 0, 0, 0, 1, 12'h000, 12'h321);
        step(0, 1, 2, 0, 0, 12'h000, 12'h000);
        n_vec++;
        if (bif.overlap_count_out !== 19'd1 || bif.count_valid_out !== 1'b1) begin
            n_err++; $display("FAIL overlap_frame2: got cnt=%0d cv=%b want cnt=1 cv=1", bif.overlap_count_out, bif.count_valid_out);
        end
    endtask

    task automatic test_random();
        int sent;
        bit did_rst;
        bit fs, v;
        sent    = 0;
        did_rst = 0;
        while (sent < 100) begin
            if (!did_rst && sent == 50) begin
                step(1, 0, 0, 0, 1, 12'hFFF, 12'hFFF);
                did_rst = 1;
                n_vec++;
                if (bif.valid_out !== 1'b0 || bif.overlap_count_out !== 19'd0 || bif.pixel_out !== 12'h000) begin
                    n_err++; $display("FAIL midstream_reset: got vld=%b pix=%h cnt=%0d want vld=0 pix=000 cnt=0",
                                      bif.valid_out, bif.pixel_out, bif.overlap_count_out);
                end
            end else begin
                fs = ($urandom_range(0, 15) == 0);
                v  = ($urandom_range(0, 3) != 0);
                step(0, fs, $urandom_range(0, 7), $urandom_range(0, 3), v, rnd_pix(), rnd_pix());
                if (v) sent++;
                n_vec++;
                if (bif.valid_out !== exp_vld || bif.pixel_out !== exp_pix ||
                    bif.overlap_count_out !== 19'(exp_cnt) || bif.count_valid_out !== exp_cv) begin
                    n_err++; $display("FAIL random_cyc%0d: got vld=%b pix=%h cnt=%0d cv=%b want vld=%b pix=%h cnt=%0d cv=%b",
                                      cyc, bif.valid_out, bif.pixel_out, bif.overlap_count_out, bif.count_valid_out,
                                      exp_vld, exp_pix, exp_cnt, exp_cv);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(0, (i == 2), 2, 0, 0, 12'h000, 12'h000);
            n_vec++;
            if (bif.valid_out !== exp_vld || bif.pixel_out !== exp_pix ||
                bif.overlap_count_out !== 19'(exp_cnt) || bif.count_valid_out !== exp_cv) begin
                n_err++; $display("FAIL random_drain%0d: got vld=%b pix=%h cnt=%0d cv=%b want vld=%b pix=%h cnt=%0d cv=%b",
                                  i, bif.valid_out, bif.pixel_out, bif.overlap_count_out, bif.count_valid_out,
                                  exp_vld, exp_pix, exp_cnt, exp_cv);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bif.frame_start_in = 1'b0;
        bif.alpha_in       = '0;
        bif.mode_in        = '0;
        bif.valid_in       = 1'b0;
        bif.pix_a_in       = '0;
        bif.pix_b_in       = '0;
        sh_alpha = F / 2; sh_mode = 0; run_cnt = 0; exp_cnt = 0;
        exp_cv = 0; exp_vld = 0; exp_pix = '0;
        test_reset();
        test_blend();
        test_shadow();
        test_modes();
        test_overlap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
